buf_index_sequencer: RTL

Drives the slot index of the instruction buffer and turns its registered output into a dispatch stream. After a fill phase (index increments until the buffer raises `start`), it walks a programmable mapping table that gives the issue order of buffer slots and presents one instruction per cycle, tagged with its slot, to the downstream decode stage. It sits between the fetch-side instruction buffer and the ESM decode/issue logic.

---
 rtl/esm_seq_pkg.sv | 22 ++
 rtl/buf_index_sequencer_map_table.sv | 32 +++
 rtl/buf_index_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/esm_seq_pkg.sv
// Shared definitions for the ESM instruction-buffer index sequencer:
// FSM state encoding, index-width helper and table reset contents.
package esm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_t;

  function automatic int idx_width(input int bs);
    return (bs < 2) ? 1 : $clog2(bs);
  endfunction

  // Reset value of mapping-table entry i: the identity mapping.
  function automatic logic [31:0] identity_entry(input int i);
    return 32'(i);
  endfunction

endpackage

// File: rtl/buf_index_sequencer_map_table.sv
// Mapping table: BS entries of IDXW bits, one synchronous write port,
// one combinational read port, asynchronous reset to the identity map.
module map_table
  import esm_seq_pkg::*;
#(
  parameter int BS   = 16,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [IDXW-1:0] waddr,
  input  logic [IDXW-1:0] wdata,
  input  logic [IDXW-1:0] raddr,
  output logic [IDXW-1:0] rdata
);

  logic [IDXW-1:0] mem [BS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        mem[i] <= IDXW'(identity_entry(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/buf_index_sequencer.sv
// Drives the instruction-buffer slot index (fill, then table-ordered walk)
// and turns the buffer's registered read data into a slot-tagged dispatch stream.
module buf_index_sequencer
  import esm_seq_pkg::*;
#(
  parameter  int BS   = 16,
  parameter  int IW   = 32,
  localparam int IDXW = idx_width(BS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            stop,
  input  logic            start,
  input  logic            map_we,
  input  logic [IDXW-1:0] map_waddr,
  input  logic [IDXW-1:0] map_wdata,
  input  logic [IDXW:0]   map_len,
  input  logic [7:0]      passes,
  input  logic [IW-1:0]   instr_buf,
  output logic [IDXW-1:0] buffer_index,
  output logic            disp_valid,
  output logic [IW-1:0]   disp_instr,
  output logic [IDXW-1:0] disp_slot,
  output logic            busy,
  output logic            done,
  output logic [2:0]      dbg_state
);

  seq_state_t      state;
  logic [IDXW-1:0] ptr;
  logic [7:0]      pass_cnt;
  logic [7:0]      passes_q;
  logic [IDXW:0]   len_q;
  logic            pend_valid;
  logic [IDXW-1:0] map_rdata;
  logic            last_entry;
  logic            last_pass;

  // Table writes only land while idle, so a write never races a dispatch read.
  map_table #(
    .BS   (BS),
    .IDXW (IDXW)
  ) u_map_table (
    .clk   (clk),
    .rst   (rst),
    .we    (map_we && (state == ST_IDLE)),
    .waddr (map_waddr),
    .wdata (map_wdata),
    .raddr (ptr),
    .rdata (map_rdata)
  );

  assign last_entry = ({1'b0, ptr} == (len_q - (IDXW+1)'(1)));
  assign last_pass  = (passes_q != 8'd0) && (pass_cnt == (passes_q - 8'd1));
  assign dbg_state  = state;
  assign disp_instr = disp_valid ? instr_buf : '0;

  // Handshake: disp_valid has no ready; every cycle it is high the consumer
  // must take disp_instr/disp_slot. An index issued at edge t yields
  // disp_valid/disp_slot after edge t+1, aligned with the buffer's read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      buffer_index <= '0;
      ptr          <= '0;
      pass_cnt     <= '0;
      passes_q     <= '0;
      len_q        <= '0;
      pend_valid   <= 1'b0;
      disp_valid   <= 1'b0;
      disp_slot    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      disp_valid <= pend_valid;
      disp_slot  <= buffer_index;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          buffer_index <= '0;
          pend_valid   <= 1'b0;
          if (go) begin
            len_q    <= map_len;
            passes_q <= passes;
            ptr      <= '0;
            pass_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          buffer_index <= buffer_index + IDXW'(1);
          if (start) begin
            if (len_q == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_DISPATCH;
            end
          end
        end
        ST_DISPATCH: begin
          buffer_index <= map_rdata;
          pend_valid   <= 1'b1;
          if (last_entry) begin
            ptr      <= '0;
            pass_cnt <= pass_cnt + 8'd1;
          end else begin
            ptr <= ptr + IDXW'(1);
          end
          // The index issued on a stop cycle still completes through DRAIN.
          if (stop || (last_entry && last_pass)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          pend_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          buffer_index <= '0;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
